// File: rtl/spi_master_if.sv
// Pin and handshake bundle between the SPI master, its local controller and the SPI slave.
// The master modport is the spi_master side; the slave modport is the controller/pin side.
interface spi_master_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] masterDataToSend;
  logic [DATA_WIDTH-1:0] masterDataReceived;
  logic                  busy;
  logic                  done;
  logic                  sclk;
  logic                  CS;
  logic                  MOSI;
  logic                  MISO;

  modport master (
    input  start, masterDataToSend, MISO,
    output masterDataReceived, busy, done, sclk, CS, MOSI
  );

  modport slave (
    output start, masterDataToSend, MISO,
    input  masterDataReceived, busy, done, sclk, CS, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// LSB-first SPI initiator, sclk idle low: MOSI changes on sclk rise, MISO sampled on sclk fall.
// Frame = CS setup half-period, 2*DATA_WIDTH sclk half-periods, CS hold half-period.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic         clk,
  input  logic         reset,
  spi_master_if.master bus
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_q, cs_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  div_end;

  assign div_end = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_end ? '0 : div_q + DIV_W'(1);
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (bus.start) begin
          tx_d    = bus.masterDataToSend;
          bit_d   = '0;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = bus.masterDataToSend[0];
          state_d = SETUP;
        end
      end
      SETUP: if (div_end) state_d = SHIFT;
      SHIFT: begin
        if (div_end) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            mosi_d = tx_q[bit_q];
          end else begin
            // Falling edge: capture MISO into the top, shifting earlier bits down (LSB first).
            sclk_d = 1'b0;
            rx_d   = {bus.MISO, rx_q[DATA_WIDTH-1:1]};
            if (bit_q == BIT_W'(DATA_WIDTH - 1)) state_d = HOLD;
            else                                 bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          cs_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rdata_d = rx_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.masterDataReceived = rdata_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.sclk               = sclk_q;
  assign bus.CS                 = cs_q;
  assign bus.MOSI               = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// Two masters (CLK_DIV=2 and CLK_DIV=1) each talking to a behavioural SPI slave;
// expectations come from the frame rules: slave word in, master word out, 18*CLK_DIV latency.
module tb_spi_master;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_if #(.DATA_WIDTH(8)) ifa ();
  spi_master_if #(.DATA_WIDTH(8)) ifb ();

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut_a (.clk(clk), .reset(rst_n), .bus(ifa));
  spi_master #(.DATA_WIDTH(8), .CLK_DIV(1)) dut_b (.clk(clk), .reset(rst_n), .bus(ifb));

  // Behavioural slaves: drive bit k of their word after sclk rise k, collect MOSI on sclk fall.
  logic [7:0] slave_word [2];
  logic [7:0] srx        [2];
  int         rise_cnt   [2];

  initial begin
    slave_word[0] = 8'h00; slave_word[1] = 8'h00;
    rise_cnt[0] = 0;       rise_cnt[1] = 0;
  end

  always @(posedge ifa.sclk or posedge ifa.CS) begin
    if (ifa.CS) begin ifa.MISO = 1'bx; rise_cnt[0] = 0; end
    else begin ifa.MISO = (rise_cnt[0] < 8) ? slave_word[0][rise_cnt[0]] : 1'bx; rise_cnt[0]++; end
  end
  always @(posedge ifb.sclk or posedge ifb.CS) begin
    if (ifb.CS) begin ifb.MISO = 1'bz; rise_cnt[1] = 0; end
    else begin ifb.MISO = (rise_cnt[1] < 8) ? slave_word[1][rise_cnt[1]] : 1'bx; rise_cnt[1]++; end
  end
  always @(negedge ifa.sclk) srx[0] = {ifa.MOSI, srx[0][7:1]};
  always @(negedge ifb.sclk) srx[1] = {ifb.MOSI, srx[1][7:1]};

  // Monitor: done pulses and sclk-high clock counts, sampled mid-cycle.
  int done_cnt [2] = '{0, 0};
  int done_last[2] = '{0, 0};
  int sclk_hi  [2] = '{0, 0};
  always @(negedge clk) begin
    if (ifa.done === 1'b1) begin done_cnt[0]++; done_last[0] = cyc; end
    if (ifb.done === 1'b1) begin done_cnt[1]++; done_last[1] = cyc; end
    if (ifa.sclk === 1'b1) sclk_hi[0]++;
    if (ifb.sclk === 1'b1) sclk_hi[1]++;
  end

  task automatic drive(input int sel, input logic st, input logic [7:0] d);
    if (sel == 1) begin ifb.start = st; ifb.masterDataToSend = d; end
    else          begin ifa.start = st; ifa.masterDataToSend = d; end
  endtask

  function automatic logic [7:0] rdata(input int sel);
    return (sel == 1) ? ifb.masterDataReceived : ifa.masterDataReceived;
  endfunction

  // One start pulse, optionally a second start (word FF) while busy; reports observations.
  task automatic xfer(input int sel, input logic [7:0] m, input logic [7:0] s, input bit junk,
                      output int lat, output int nd, output logic [7:0] mid_rx, output int hi);
    int acc, base, hbase;
    slave_word[sel] = s;
    base  = done_cnt[sel];
    hbase = sclk_hi[sel];
    lat   = -1;
    mid_rx = 'x;
    @(negedge clk); drive(sel, 1'b1, m);
    @(negedge clk); drive(sel, 1'b0, m); acc = cyc;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (i == 8) mid_rx = rdata(sel);
      if (junk && i == 10) drive(sel, 1'b1, 8'hFF);
      if (junk && i == 11) drive(sel, 1'b0, 8'hFF);
      if (done_cnt[sel] != base) break;
    end
    if (done_cnt[sel] != base) lat = done_last[sel] - acc;
    repeat (8) @(negedge clk);
    #1;
    nd = done_cnt[sel] - base;
    hi = sclk_hi[sel] - hbase;
  endtask

  task automatic test_reset;
    tests++;
    if ({ifa.CS, ifa.sclk, ifa.busy, ifa.done} !== 4'b1000) begin
      fails++; $display("FAIL reset_pins_a: got %b want 1000", {ifa.CS, ifa.sclk, ifa.busy, ifa.done});
    end
    tests++;
    if ({ifb.CS, ifb.sclk, ifb.busy, ifb.done, ifb.masterDataReceived} !== {4'b1000, 8'h00}) begin
      fails++; $display("FAIL reset_pins_b: got %b %h want 1000 00", {ifb.CS, ifb.sclk, ifb.busy, ifb.done}, ifb.masterDataReceived);
    end
  endtask

  task automatic test_basic;
    int lat, nd, hi; logic [7:0] mid;
    xfer(0, 8'hA5, 8'h3C, 1'b0, lat, nd, mid, hi);
    tests++; if (srx[0] !== 8'hA5) begin fails++; $display("FAIL basic_mosi: got %h want a5", srx[0]); end
    tests++; if (rdata(0) !== 8'h3C) begin fails++; $display("FAIL basic_rx: got %h want 3c", rdata(0)); end
    tests++; if (lat != 36) begin fails++; $display("FAIL basic_latency: got %0d want 36", lat); end
    tests++; if (nd != 1) begin fails++; $display("FAIL basic_done_count: got %0d want 1", nd); end
    tests++; if (hi != 16) begin fails++; $display("FAIL basic_sclk_high: got %0d want 16", hi); end
  endtask

  task automatic test_reset_mid;
    int base;
    slave_word[0] = 8'h77;
    @(negedge clk); drive(0, 1'b1, 8'h12);
    @(negedge clk); drive(0, 1'b0, 8'h12);
    repeat (12) @(negedge clk);
    base  = done_cnt[0];
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ifa.CS, ifa.sclk, ifa.busy, ifa.done, ifa.masterDataReceived} !== {4'b1000, 8'h00}) begin
      fails++; $display("FAIL reset_mid: got %b %h want 1000 00", {ifa.CS, ifa.sclk, ifa.busy, ifa.done}, ifa.masterDataReceived);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    tests++; if (done_cnt[0] != base) begin fails++; $display("FAIL reset_no_done: got %0d want 0", done_cnt[0] - base); end
    tests++; if (ifa.masterDataReceived !== 8'h00) begin fails++; $display("FAIL reset_rx_hold: got %h want 00", ifa.masterDataReceived); end
  endtask

  task automatic test_ignore_start;
    int lat, nd, hi; logic [7:0] mid, prev;
    prev = rdata(0);
    xfer(0, 8'h5A, 8'hE1, 1'b1, lat, nd, mid, hi);
    tests++; if (srx[0] !== 8'h5A) begin fails++; $display("FAIL ignore_mosi: got %h want 5a", srx[0]); end
    tests++; if (nd != 1) begin fails++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
    tests++; if (mid !== prev) begin fails++; $display("FAIL ignore_no_partial: got %h want %h", mid, prev); end
    tests++; if (rdata(0) !== 8'hE1) begin fails++; $display("FAIL ignore_rx: got %h want e1", rdata(0)); end
  endtask

  task automatic test_back_to_back;
    int base; logic [7:0] s1, s2;
    s1 = 8'($urandom); s2 = 8'($urandom);
    slave_word[0] = s1;
    base = done_cnt[0];
    @(negedge clk); drive(0, 1'b1, 8'h01);
    for (int i = 0; i < 200 && done_cnt[0] == base; i++) begin @(negedge clk); #1; end
    tests++; if (done_cnt[0] != base + 1) begin fails++; $display("FAIL b2b_first_done: got %0d want 1", done_cnt[0] - base); end
    tests++; if (rdata(0) !== s1 || srx[0] !== 8'h01) begin fails++; $display("FAIL b2b_first_words: got %h/%h want %h/01", rdata(0), srx[0], s1); end
    tests++; if (ifa.CS !== 1'b1) begin fails++; $display("FAIL b2b_cs_high: got %b want 1", ifa.CS); end
    drive(0, 1'b1, 8'h80);
    slave_word[0] = s2;
    @(negedge clk); #1;
    tests++; if (ifa.CS !== 1'b0) begin fails++; $display("FAIL b2b_cs_gap: got %b want 0", ifa.CS); end
    for (int i = 0; i < 200 && done_cnt[0] == base + 1; i++) begin @(negedge clk); #1; end
    drive(0, 1'b0, 8'h80);
    tests++; if (rdata(0) !== s2 || srx[0] !== 8'h80) begin fails++; $display("FAIL b2b_second_words: got %h/%h want %h/80", rdata(0), srx[0], s2); end
    repeat (40) @(negedge clk);
    #1;
    tests++; if (done_cnt[0] != base + 2) begin fails++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt[0] - base); end
  endtask

  task automatic test_div1;
    int lat, nd, hi; logic [7:0] mid;
    xfer(1, 8'hFF, 8'h00, 1'b0, lat, nd, mid, hi);
    tests++; if (lat != 18) begin fails++; $display("FAIL div1_latency: got %0d want 18", lat); end
    tests++; if (hi != 8) begin fails++; $display("FAIL div1_sclk_high: got %0d want 8", hi); end
    tests++; if (rdata(1) !== 8'h00 || srx[1] !== 8'hFF) begin fails++; $display("FAIL div1_words: got %h/%h want 00/ff", rdata(1), srx[1]); end
  endtask

  task automatic test_slave_pair;
    int lat, nd, hi; logic [7:0] mid;
    xfer(0, 8'h96, 8'hC3, 1'b0, lat, nd, mid, hi);
    tests++; if (rdata(0) !== 8'hC3) begin fails++; $display("FAIL pair_master_rx: got %h want c3", rdata(0)); end
    tests++; if (srx[0] !== 8'h96) begin fails++; $display("FAIL pair_slave_rx: got %h want 96", srx[0]); end
  endtask

  task automatic test_random;
    int lat, nd, hi, sel; logic [7:0] m, s, mid;
    for (int k = 0; k < 8; k++) begin
      sel = k % 2;
      m = 8'($urandom); s = 8'($urandom);
      xfer(sel, m, s, k[2], lat, nd, mid, hi);
      tests++;
      if (rdata(sel) !== s || srx[sel] !== m) begin
        fails++; $display("FAIL rand_words[%0d]: got %h/%h want %h/%h", k, rdata(sel), srx[sel], s, m);
      end
      tests++;
      if (lat != 18 * (2 - sel) || nd != 1) begin
        fails++; $display("FAIL rand_timing[%0d]: got lat %0d dones %0d want %0d 1", k, lat, nd, 18 * (2 - sel));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_basic;
    test_reset_mid;
    test_ignore_start;
    test_back_to_back;
    test_div1;
    test_slave_pair;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
